// File: rtl/fetch_unit.sv
// Instruction-fetch stage with IF/ID pipeline register: PC, next-PC selection,
// stall hold, one-bubble redirect and end-of-memory stop.
module fetch_unit #(
    parameter int          DWIDTH     = 32,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [31:0]       imem_addr,
    input  logic [DWIDTH-1:0] imem_rdata,
    input  logic              stall,
    input  logic [1:0]        jump_type,
    input  logic [31:0]       jump_addr,
    input  logic [DWIDTH-1:0] imm,
    input  logic              branch_eq,
    input  logic [31:0]       jr_target,
    output logic [DWIDTH-1:0] id_instr,
    output logic [31:0]       id_pc,
    output logic [31:0]       id_pc_plus4,
    output logic              id_valid,
    output logic              done
);

    localparam logic [32:0] PC_LIMIT = 33'(IMEM_WORDS) * 33'd4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    state_e            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [DWIDTH-1:0] idInstr_q, idInstr_d;
    logic [31:0]       idPc_q, idPc_d;
    logic [31:0]       idPcPlus4_q, idPcPlus4_d;
    logic              idValid_q, idValid_d;
    logic              done_q, done_d;

    logic [31:0] pcPlus4;
    logic        seqOutOfRange;
    logic [31:0] immWord;
    logic [31:0] branchTarget;
    logic [31:0] jumpTarget;
    logic [31:0] jrTarget;
    logic        redirectTaken;
    logic [31:0] redirectTarget;
    logic        targetInRange;
    logic        unusedBits;

    assign pcPlus4       = pc_q + 32'd4;
    assign seqOutOfRange = ({1'b0, pc_q} + 33'd4) >= PC_LIMIT;
    assign immWord       = 32'(imm);
    assign branchTarget  = idPcPlus4_q + (immWord << 2);
    assign jumpTarget    = {idPcPlus4_q[31:28], jump_addr[25:0], 2'b00};
    assign jrTarget      = {jr_target[31:2], 2'b00};
    assign targetInRange = {1'b0, redirectTarget} < PC_LIMIT;
    assign unusedBits    = ^{jump_addr[31:26], jr_target[1:0]};

    // Redirect decisions only apply to a real instruction sitting in IF/ID.
    always_comb begin
        redirectTaken  = 1'b0;
        redirectTarget = branchTarget;
        if (idValid_q) begin
            case (jump_type)
                2'b01: redirectTaken = branch_eq;
                2'b10: begin
                    redirectTaken  = 1'b1;
                    redirectTarget = jumpTarget;
                end
                2'b11: begin
                    redirectTaken  = 1'b1;
                    redirectTarget = jrTarget;
                end
                default: redirectTaken = 1'b0;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        idInstr_d   = idInstr_q;
        idPc_d      = idPc_q;
        idPcPlus4_d = idPcPlus4_q;
        idValid_d   = idValid_q;
        done_d      = done_q;

        case (state_q)
            IDLE: state_d = RUN;

            RUN: begin
                if (redirectTaken) begin
                    idValid_d = 1'b0;
                    idInstr_d = '0;
                    if (targetInRange) begin
                        pc_d = redirectTarget;
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end else if (!stall) begin
                    idInstr_d   = imem_rdata;
                    idPc_d      = pc_q;
                    idPcPlus4_d = pcPlus4;
                    idValid_d   = 1'b1;
                    // The last in-range word is still captured; only the PC freezes.
                    if (seqOutOfRange) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        pc_d = pcPlus4;
                    end
                end
            end

            DONE: begin
                if (redirectTaken) begin
                    idValid_d = 1'b0;
                    idInstr_d = '0;
                    if (targetInRange) begin
                        pc_d    = redirectTarget;
                        state_d = RUN;
                    end
                end else if (!stall) begin
                    idValid_d = 1'b0;
                    idInstr_d = '0;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            idInstr_q   <= '0;
            idPc_q      <= '0;
            idPcPlus4_q <= '0;
            idValid_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            idInstr_q   <= idInstr_d;
            idPc_q      <= idPc_d;
            idPcPlus4_q <= idPcPlus4_d;
            idValid_q   <= idValid_d;
            done_q      <= done_d;
        end
    end

    assign imem_addr   = pc_q;
    assign id_instr    = idInstr_q;
    assign id_pc       = idPc_q;
    assign id_pc_plus4 = idPcPlus4_q;
    assign id_valid    = idValid_q;
    assign done        = done_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed scoreboard bench for fetch_unit: a 256-word instance for fetch/redirect/stall
// and a 4-word instance for end-of-memory, both fed the same decode-side inputs.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic [1:0]  jumpType;
    logic [31:0] jumpAddr;
    logic [31:0] imm;
    logic        branchEq;
    logic [31:0] jrTarget;

    logic [31:0] bigAddr, bigRdata, bigInstr, bigPc, bigPcPlus4;
    logic        bigValid, bigDone;
    logic [31:0] smallAddr, smallRdata, smallInstr, smallPc, smallPcPlus4;
    logic        smallValid, smallDone;

    int checkCount = 0;
    int passCount  = 0;

    typedef struct {
        logic        sel;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] addr;
        logic        done;
    } exp_t;

    exp_t expQ[$];

    function automatic logic [31:0] instrAt(input logic [31:0] a);
        return {8'hA5, a[23:0]} ^ 32'h0013_5700;
    endfunction

    assign bigRdata   = instrAt(bigAddr);
    assign smallRdata = instrAt(smallAddr);

    fetch_unit #(.DWIDTH(32), .RESET_PC(32'h0), .IMEM_WORDS(256)) dutBig (
        .clk(clk), .rst_n(rst_n), .imem_addr(bigAddr), .imem_rdata(bigRdata),
        .stall(stall), .jump_type(jumpType), .jump_addr(jumpAddr), .imm(imm),
        .branch_eq(branchEq), .jr_target(jrTarget), .id_instr(bigInstr),
        .id_pc(bigPc), .id_pc_plus4(bigPcPlus4), .id_valid(bigValid), .done(bigDone)
    );

    fetch_unit #(.DWIDTH(32), .RESET_PC(32'h0), .IMEM_WORDS(4)) dutSmall (
        .clk(clk), .rst_n(rst_n), .imem_addr(smallAddr), .imem_rdata(smallRdata),
        .stall(stall), .jump_type(jumpType), .jump_addr(jumpAddr), .imm(imm),
        .branch_eq(branchEq), .jr_target(jrTarget), .id_instr(smallInstr),
        .id_pc(smallPc), .id_pc_plus4(smallPcPlus4), .id_valid(smallValid), .done(smallDone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic applyStimulus(input logic st, input logic [1:0] jt, input logic [31:0] ja,
                                 input logic [31:0] im, input logic be, input logic [31:0] jr,
                                 input logic sel, input logic ev, input logic [31:0] epc,
                                 input logic [31:0] eaddr, input logic ed);
        exp_t e;
        stall    = st;
        jumpType = jt;
        jumpAddr = ja;
        imm      = im;
        branchEq = be;
        jrTarget = jr;
        e.sel   = sel;
        e.valid = ev;
        e.pc    = epc;
        e.addr  = eaddr;
        e.done  = ed;
        expQ.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t        e;
        logic        v, d;
        logic [31:0] a, p, ins, p4;
        @(negedge clk);
        e = expQ.pop_front();
        if (e.sel) begin
            v = smallValid; d = smallDone; a = smallAddr; p = smallPc; ins = smallInstr; p4 = smallPcPlus4;
        end else begin
            v = bigValid; d = bigDone; a = bigAddr; p = bigPc; ins = bigInstr; p4 = bigPcPlus4;
        end
        check("id_valid", 32'(v), 32'(e.valid));
        check("imem_addr", a, e.addr);
        check("done", 32'(d), 32'(e.done));
        if (e.valid) begin
            check("id_pc", p, e.pc);
            check("id_instr", ins, instrAt(e.pc));
            check("id_pc_plus4", p4, e.pc + 32'd4);
        end
    endtask

    task automatic step(input logic st, input logic [1:0] jt, input logic [31:0] ja,
                        input logic [31:0] im, input logic be, input logic [31:0] jr,
                        input logic sel, input logic ev, input logic [31:0] epc,
                        input logic [31:0] eaddr, input logic ed);
        applyStimulus(st, jt, ja, im, be, jr, sel, ev, epc, eaddr, ed);
        checkOutput();
    endtask

    task automatic seqStep(input logic sel, input logic ev, input logic [31:0] epc,
                           input logic [31:0] eaddr, input logic ed);
        step(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0, sel, ev, epc, eaddr, ed);
    endtask

    // Reset is checked a few ns after assertion, before any clock edge arrives.
    task automatic doReset();
        #2 rst_n = 1'b0;
        #1;
        check("rst_id_valid", 32'(bigValid), 32'h0);
        check("rst_id_pc", bigPc, 32'h0);
        check("rst_id_instr", bigInstr, 32'h0);
        check("rst_id_pc_plus4", bigPcPlus4, 32'h0);
        check("rst_done", 32'(bigDone), 32'h0);
        check("rst_imem_addr", bigAddr, 32'h0);
        check("rst_small_valid", 32'(smallValid), 32'h0);
        check("rst_small_done", 32'(smallDone), 32'h0);
        check("rst_small_addr", smallAddr, 32'h0);
        @(negedge clk);
        stall    = 1'b0;
        jumpType = 2'b00;
        jumpAddr = 32'h0;
        imm      = 32'h0;
        branchEq = 1'b0;
        jrTarget = 32'h0;
        rst_n    = 1'b1;
    endtask

    task automatic startup(input logic sel, input int n);
        seqStep(sel, 1'b0, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < n; i++) begin
            seqStep(sel, 1'b1, 32'(4 * i), 32'(4 * i + 4), 1'b0);
        end
    endtask

    initial begin
        rst_n    = 1'b1;
        stall    = 1'b0;
        jumpType = 2'b00;
        jumpAddr = 32'h0;
        imm      = 32'h0;
        branchEq = 1'b0;
        jrTarget = 32'h0;

        $display("[TB] reset and sequential fetch");
        doReset();
        startup(1'b0, 3);

        $display("[TB] jump absolute and jump register");
        step(1'b0, 2'b10, 32'h40, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h100, 1'b0);
        seqStep(1'b0, 1'b1, 32'h100, 32'h104, 1'b0);
        step(1'b0, 2'b11, 32'h0, 32'h0, 1'b0, 32'h3E, 1'b0, 1'b0, 32'h0, 32'h3C, 1'b0);
        seqStep(1'b0, 1'b1, 32'h3C, 32'h40, 1'b0);

        $display("[TB] taken and not-taken branch");
        step(1'b0, 2'b11, 32'h0, 32'h0, 1'b0, 32'h10, 1'b0, 1'b0, 32'h0, 32'h10, 1'b0);
        seqStep(1'b0, 1'b1, 32'h10, 32'h14, 1'b0);
        step(1'b0, 2'b01, 32'h0, 32'd3, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h20, 1'b0);
        seqStep(1'b0, 1'b1, 32'h20, 32'h24, 1'b0);
        step(1'b0, 2'b10, 32'h4, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h10, 1'b0);
        step(1'b0, 2'b10, 32'h80, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h10, 32'h14, 1'b0);
        step(1'b0, 2'b01, 32'h0, 32'd3, 1'b0, 32'h0, 1'b0, 1'b1, 32'h14, 32'h18, 1'b0);
        step(1'b0, 2'b01, 32'h0, 32'hFFFF_FFFE, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h10, 1'b0);
        seqStep(1'b0, 1'b1, 32'h10, 32'h14, 1'b0);

        $display("[TB] stall, then stall with jump");
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h10, 32'h14, 1'b0);
        end
        step(1'b1, 2'b10, 32'h30, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'hC0, 1'b0);
        seqStep(1'b0, 1'b1, 32'hC0, 32'hC4, 1'b0);

        $display("[TB] out-of-range redirect");
        step(1'b0, 2'b11, 32'h0, 32'h0, 1'b0, 32'h400, 1'b0, 1'b0, 32'h0, 32'hC4, 1'b1);
        seqStep(1'b0, 1'b0, 32'h0, 32'hC4, 1'b1);

        $display("[TB] end of memory, drain");
        doReset();
        startup(1'b1, 3);
        seqStep(1'b1, 1'b1, 32'hC, 32'hC, 1'b1);
        seqStep(1'b1, 1'b0, 32'h0, 32'hC, 1'b1);
        step(1'b0, 2'b10, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'hC, 1'b1);
        seqStep(1'b1, 1'b0, 32'h0, 32'hC, 1'b1);

        $display("[TB] end of memory, jump back");
        doReset();
        startup(1'b1, 3);
        seqStep(1'b1, 1'b1, 32'hC, 32'hC, 1'b1);
        step(1'b0, 2'b10, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1);
        seqStep(1'b1, 1'b1, 32'h0, 32'h4, 1'b1);
        seqStep(1'b1, 1'b1, 32'h4, 32'h8, 1'b1);

        $display("[TB] reset during redirect");
        doReset();
        startup(1'b0, 2);
        jumpType = 2'b10;
        jumpAddr = 32'h40;
        doReset();
        startup(1'b0, 3);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
